// File: rtl/shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_pkg
// Description : Shared widths, op encodings and output-state encoding for the
//               two-requester shift arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
// Module      : shift_core
// Description : Combinational 5-stage logarithmic shifter (sll / sra).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_core
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_op,
    output logic [DATA_W-1:0]  o_result
);

    logic [DATA_W-1:0] w_stage [0:SHAMT_W];
    logic              w_fill;

    assign w_fill     = (i_op == OP_SRA) ? i_data[DATA_W-1] : 1'b0;
    assign w_stage[0] = i_data;

    // Stage i shifts by 2**i when shamt bit i is set.
    generate
        for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
            localparam int SH = 1 << i;
            assign w_stage[i+1] = !i_shamt[i]        ? w_stage[i] :
                                  (i_op == OP_SLL)  ? {w_stage[i][DATA_W-1-SH:0], {SH{1'b0}}} :
                                                      {{SH{w_fill}}, w_stage[i][DATA_W-1:SH]};
        end
    endgenerate

    assign o_result = w_stage[SHAMT_W];

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Two requesters share one shifter; grant, one-entry result
//               register and EMPTY/FULL output state live here.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic               clock,
    input  logic               resetn,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req0_op,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic               req1_op,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_id
);

    state_t             r_state;
    logic [DATA_W-1:0]  r_data;
    logic               r_id;
    logic               r_last;

    logic               w_can_accept;
    logic               w_grant;
    logic               w_accept;
    logic [DATA_W-1:0]  w_sel_data;
    logic [SHAMT_W-1:0] w_sel_shamt;
    logic               w_sel_op;
    logic [DATA_W-1:0]  w_result;

    assign w_can_accept = (r_state == EMPTY) || rsp_ready;

    // Contested cycles go to whoever did not win the last accept (RR) or to 0.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = (RR_EN != 0) ? ~r_last : 1'b0;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = w_can_accept && !w_grant && req0_valid;
    assign req1_ready = w_can_accept &&  w_grant && req1_valid;
    assign w_accept   = req0_ready || req1_ready;

    assign w_sel_data  = w_grant ? req1_data  : req0_data;
    assign w_sel_shamt = w_grant ? req1_shamt : req0_shamt;
    assign w_sel_op    = w_grant ? req1_op    : req0_op;

    shift_core u_core (
        .i_data   (w_sel_data),
        .i_shamt  (w_sel_shamt),
        .i_op     (w_sel_op),
        .o_result (w_result)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (!w_accept && rsp_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
            if (w_accept) begin
                r_data <= w_result;
                r_id   <= w_grant;
                r_last <= w_grant;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Self-checking bench; round-robin and fixed-priority instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        v0, v1, o0, o1, rr;
    logic [31:0] d0, d1;
    logic [4:0]  s0, s1;

    logic [1:0]  r0_ready, r1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_data [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.RR_EN(1)) u_rr (
        .clock(clk), .resetn(resetn),
        .req0_valid(v0), .req0_ready(r0_ready[0]), .req0_data(d0), .req0_shamt(s0), .req0_op(o0),
        .req1_valid(v1), .req1_ready(r1_ready[0]), .req1_data(d1), .req1_shamt(s1), .req1_op(o1),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rr), .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0])
    );

    shift_arbiter #(.RR_EN(0)) u_fp (
        .clock(clk), .resetn(resetn),
        .req0_valid(v0), .req0_ready(r0_ready[1]), .req0_data(d0), .req0_shamt(s0), .req0_op(o0),
        .req1_valid(v1), .req1_ready(r1_ready[1]), .req1_data(d1), .req1_shamt(s1), .req1_op(o1),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rr), .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1])
    );

    // Reference model: index 0 = round-robin instance, 1 = fixed priority.
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    bit          m_id    [2];
    bit          m_last  [2];

    function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic op);
        if (!op) return d << s;
        return 32'($signed(d) >>> s);
    endfunction

    function automatic bit ref_grant(int k);
        if (v0 && v1) return (k == 0) ? !m_last[k] : 1'b0;
        return v1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_id[k]    = 1'b0;
            m_last[k]  = 1'b1;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit          acc [2];
        bit          g   [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit can;
            can    = !m_valid[k] || rr;
            g[k]   = ref_grant(k);
            acc[k] = can && (v0 || v1);
            chk($sformatf("req0_ready[%0d]", k), 32'(r0_ready[k]), 32'(can && v0 && !g[k]));
            chk($sformatf("req1_ready[%0d]", k), 32'(r1_ready[k]), 32'(can && v1 &&  g[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                m_valid[k] = 1'b1;
                m_data[k]  = g[k] ? ref_shift(d1, s1, o1) : ref_shift(d0, s0, o0);
                m_id[k]    = g[k];
                m_last[k]  = g[k];
            end else if (rr) begin
                m_valid[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(m_valid[k]));
            if (m_valid[k]) begin
                chk($sformatf("rsp_data[%0d]", k), rsp_data[k], m_data[k]);
                chk($sformatf("rsp_id[%0d]", k), 32'(rsp_id[k]), 32'(m_id[k]));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("reset data[%0d]", k), rsp_data[k], 32'd0);
            chk($sformatf("reset id[%0d]", k), 32'(rsp_id[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit          who;
        logic [31:0] d;
        logic [4:0]  s;
        bit          op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];
    bit   exp_rr [4];

    initial begin
        v0 = 0; v1 = 0; o0 = 0; o1 = 0; rr = 1;
        d0 = 0; d1 = 0; s0 = 0; s1 = 0;
        resetn = 1'b0;

        vecs[0] = '{0, 32'h00000001, 5'd31, 1'b0, 32'h80000000};
        vecs[1] = '{1, 32'h80000000, 5'd4,  1'b1, 32'hF8000000};
        vecs[2] = '{1, 32'h40000000, 5'd4,  1'b1, 32'h04000000};
        vecs[3] = '{0, 32'hA5A5A5A5, 5'd0,  1'b0, 32'hA5A5A5A5};
        vecs[4] = '{1, 32'hA5A5A5A5, 5'd0,  1'b1, 32'hA5A5A5A5};
        vecs[5] = '{0, 32'hFFFFFFFF, 5'd1,  1'b0, 32'hFFFFFFFE};
        vecs[6] = '{1, 32'h12345678, 5'd8,  1'b0, 32'h34567800};
        vecs[7] = '{0, 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
        vecs[8] = '{1, 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000};
        vecs[9] = '{0, 32'h0000F000, 5'd12, 1'b1, 32'h0000000F};
        exp_rr  = '{0, 1, 0, 1};

        @(negedge clk);
        do_reset();

        // Directed single-requester vectors.
        foreach (vecs[i]) begin
            v0 = !vecs[i].who; v1 = vecs[i].who; rr = 1;
            d0 = vecs[i].d; s0 = vecs[i].s; o0 = vecs[i].op;
            d1 = vecs[i].d; s1 = vecs[i].s; o1 = vecs[i].op;
            cycle();
            chk($sformatf("vec%0d data", i), rsp_data[0], vecs[i].exp);
            chk($sformatf("vec%0d id", i), 32'(rsp_id[0]), 32'(vecs[i].who));
        end
        v0 = 0; v1 = 0;
        cycle();

        // Contested stream straight out of reset.
        do_reset();
        v0 = 1; v1 = 1; rr = 1;
        d0 = 32'h1; s0 = 5'd1; o0 = 0; d1 = 32'h2; s1 = 5'd1; o1 = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("rr seq %0d", i), 32'(rsp_id[0]), 32'(exp_rr[i]));
            chk($sformatf("fp seq %0d", i), 32'(rsp_id[1]), 32'd0);
            chk($sformatf("no bubble %0d", i), 32'(rsp_valid), 32'b11);
        end

        // Hold under backpressure, then pass-through accept.
        v1 = 0; d0 = 32'h3; s0 = 5'd2; o0 = 0;
        cycle();
        rr = 0;
        for (int i = 0; i < 3; i++) begin
            d0 = $urandom; s0 = 5'($urandom);
            cycle();
            chk($sformatf("hold data %0d", i), rsp_data[0], 32'h0000000C);
            chk($sformatf("hold readies %0d", i), {30'd0, r0_ready[0], r1_ready[0]}, 32'd0);
        end
        rr = 1; d0 = 32'h100; s0 = 5'd4; o0 = 0;
        cycle();
        chk("pass-through data", rsp_data[0], 32'h00001000);
        chk("pass-through valid", 32'(rsp_valid[0]), 32'd1);

        // Asynchronous reset while FULL, between edges.
        v0 = 0; rr = 0;
        resetn = 1'b0;
        #1;
        chk("async valid rr", 32'(rsp_valid[0]), 32'd0);
        chk("async valid fp", 32'(rsp_valid[1]), 32'd0);
        chk("async data", rsp_data[0], 32'd0);
        #1;
        resetn = 1'b1;
        model_reset();
        v0 = 1; v1 = 1; rr = 1;
        cycle();
        chk("post-reset grant", 32'(rsp_id[0]), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            d0 = $urandom; d1 = $urandom;
            s0 = 5'($urandom); s1 = 5'($urandom);
            o0 = 1'($urandom); o1 = 1'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
